// File: rtl/mont_mul_feeder.sv
// Front end of a Montgomery multiplier: forms the full a*b product with a
// shift-and-add loop and hands the low word plus modulus side-band to the reducer.
module mont_mul_feeder #(
   parameter int DATA_LENGTH = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [DATA_LENGTH-1:0] a_i,
   input  logic [DATA_LENGTH-1:0] b_i,
   input  logic [DATA_LENGTH-1:0] m_i,
   input  logic [DATA_LENGTH-1:0] m_bl_i,
   input  logic [DATA_LENGTH-1:0] minv_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [DATA_LENGTH-1:0] x_o,
   output logic [DATA_LENGTH-1:0] m_o,
   output logic [DATA_LENGTH-1:0] m_bl_o,
   output logic [DATA_LENGTH-1:0] minv_o,
   output logic                   start_o,
   output logic                   ovf_o
);

   localparam int W     = DATA_LENGTH;
   localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

   state_t             state, state_next;
   logic [W-1:0]       a_reg, b_reg, m_reg, m_bl_reg, minv_reg;
   logic [2*W-1:0]     acc, acc_next, a_ext;
   logic [CNT_W-1:0]   cnt;
   logic               last_bit;

   // Accumulator is twice the operand width, so no partial sum can wrap.
   assign a_ext    = {{W{1'b0}}, a_reg};
   assign acc_next = b_reg[cnt] ? (acc + (a_ext << cnt)) : acc;
   assign last_bit = (cnt == CNT_W'(W - 1));

   assign in_ready_o  = (state == IDLE);
   assign out_valid_o = (state == HOLD);
   assign start_o     = out_valid_o & out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid_i)  state_next = MUL;
         MUL:     if (last_bit)    state_next = HOLD;
         HOLD:    if (out_ready_i) state_next = IDLE;
         default:                  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_reg    <= '0;
         b_reg    <= '0;
         m_reg    <= '0;
         m_bl_reg <= '0;
         minv_reg <= '0;
         acc      <= '0;
         cnt      <= '0;
         x_o      <= '0;
         m_o      <= '0;
         m_bl_o   <= '0;
         minv_o   <= '0;
         ovf_o    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid_i) begin
                  a_reg    <= a_i;
                  b_reg    <= b_i;
                  m_reg    <= m_i;
                  m_bl_reg <= m_bl_i;
                  minv_reg <= minv_i;
                  acc      <= '0;
                  cnt      <= '0;
               end
            end
            MUL: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               // Output registers load only on entry to HOLD so they keep the
               // previous result visible while the next product is built.
               if (last_bit) begin
                  x_o    <= acc_next[W-1:0];
                  ovf_o  <= |acc_next[2*W-1:W];
                  m_o    <= m_reg;
                  m_bl_o <= m_bl_reg;
                  minv_o <= minv_reg;
               end
            end
            HOLD: begin
               if (out_ready_i) ovf_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mont_mul_feeder.sv
// Scoreboard bench for mont_mul_feeder at W=64: directed operand sets with
// hand-computed products, checked by an independent output monitor.
module tb_mont_mul_feeder;

   localparam int W       = 64;
   localparam int LATENCY = W + 1;

   typedef struct {
      logic [63:0] x;
      logic        ovf;
      logic [63:0] m;
      logic [63:0] mbl;
      logic [63:0] minv;
      int          acc_cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_i, in_valid_i, out_ready_i;
   logic          in_ready_o, out_valid_o, start_o, ovf_o;
   logic [W-1:0]  a_i, b_i, m_i, m_bl_i, minv_i;
   logic [W-1:0]  x_o, m_o, m_bl_o, minv_o;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_hs = 0;
   int   hs_cyc = 0;
   int   last_acc = 0;
   int   cyc = 0;

   mont_mul_feeder #(.DATA_LENGTH(W)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .a_i        (a_i),
      .b_i        (b_i),
      .m_i        (m_i),
      .m_bl_i     (m_bl_i),
      .minv_i     (minv_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .x_o        (x_o),
      .m_o        (m_o),
      .m_bl_o     (m_bl_o),
      .minv_o     (minv_o),
      .start_o    (start_o),
      .ovf_o      (ovf_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic timeout_fail(input string name);
      n_chk++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // Called at posedge+#1; leaves in_valid_i high after the accepting edge.
   task automatic present(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m,
                          input logic [63:0] mbl, input logic [63:0] minv,
                          input logic [63:0] ex, input logic eo);
      exp_t e;
      int   w;
      a_i = a; b_i = b; m_i = m; m_bl_i = mbl; minv_i = minv;
      in_valid_i = 1'b1;
      w = 0;
      while (!in_ready_o && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready_o) begin
         timeout_fail("accept");
         return;
      end
      e.x = ex; e.ovf = eo; e.m = m; e.mbl = mbl; e.minv = minv;
      e.acc_cyc = cyc + 1;
      last_acc  = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic wait_done();
      int w;
      w = 0;
      while ((sb.size() != 0 || !in_ready_o) && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      if (sb.size() != 0 || !in_ready_o) timeout_fail("result");
   endtask

   task automatic run(input logic [63:0] a, input logic [63:0] b, input logic [63:0] ex,
                      input logic eo);
      present(a, b, 64'd17, 64'd5, 64'd15, ex, eo);
      in_valid_i = 1'b0;
      wait_done();
   endtask

   // Output monitor: latency, handshake payload, HOLD stability, start pulses.
   initial begin : monitor
      logic        prev_valid;
      logic [63:0] px, pm, pbl, pinv;
      logic        povf;
      exp_t        e;
      prev_valid = 1'b0;
      px = '0; pm = '0; pbl = '0; pinv = '0; povf = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            prev_valid = 1'b0;
         end else begin
            if (out_valid_o && !prev_valid) begin
               if (sb.size() == 0) timeout_fail("unexpected_valid");
               else chk("latency", 64'(cyc - sb[0].acc_cyc + 1), 64'(LATENCY));
            end
            if (out_valid_o && prev_valid) begin
               chk("hold_x", x_o, px);
               chk("hold_ovf", 64'(ovf_o), 64'(povf));
               chk("hold_m", m_o, pm);
               chk("hold_mbl", m_bl_o, pbl);
               chk("hold_minv", minv_o, pinv);
            end
            if (out_valid_o) chk("in_ready_in_hold", 64'(in_ready_o), 64'd0);
            else             chk("ovf_outside_hold", 64'(ovf_o), 64'd0);
            if (out_valid_o && out_ready_i) begin
               chk("start_pulse", 64'(start_o), 64'd1);
               if (sb.size() == 0) begin
                  timeout_fail("unexpected_handshake");
               end else begin
                  e = sb.pop_front();
                  chk("x", x_o, e.x);
                  chk("ovf", 64'(ovf_o), 64'(e.ovf));
                  chk("m", m_o, e.m);
                  chk("m_bl", m_bl_o, e.mbl);
                  chk("minv", minv_o, e.minv);
               end
               hs_cyc = cyc + 1;
               n_hs++;
            end else begin
               chk("no_start", 64'(start_o), 64'd0);
            end
            prev_valid = out_valid_o;
            px = x_o; povf = ovf_o; pm = m_o; pbl = m_bl_o; pinv = minv_o;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
      a_i = '0; b_i = '0; m_i = '0; m_bl_i = '0; minv_i = '0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      chk("rst_in_ready", 64'(in_ready_o), 64'd1);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_x", x_o, 64'd0);
      chk("rst_m", m_o, 64'd0);

      run(64'd3, 64'd5, 64'd15, 1'b0);
      run(64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1);
      run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      run(64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      run(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);

      // Backpressure: stall in HOLD with stray in_valid pulses.
      out_ready_i = 1'b0;
      present(64'd1000, 64'd1000, 64'h1234, 64'd13, 64'h55, 64'd1000000, 1'b0);
      in_valid_i = 1'b0;
      for (int w = 0; w < 300 && !out_valid_o; w++) begin
         @(posedge clk); #1;
      end
      if (!out_valid_o) timeout_fail("bp_valid");
      a_i = 64'd5; b_i = 64'd5; m_i = 64'd99;
      for (int i = 0; i < 10; i++) begin
         in_valid_i = (i % 2 == 0);
         @(posedge clk); #1;
      end
      in_valid_i = 1'b0;
      @(posedge clk); #1;
      out_ready_i = 1'b1;
      wait_done();

      // Reset in the middle of MUL, with in_valid asserted on the reset edge.
      present(64'd9, 64'd9, 64'd17, 64'd5, 64'd15, 64'd81, 1'b0);
      in_valid_i = 1'b0;
      repeat (29) @(posedge clk);
      #1 rst_i = 1'b1; in_valid_i = 1'b1;
      sb.delete();
      @(posedge clk);
      #1 rst_i = 1'b0; in_valid_i = 1'b0;
      chk("abort_in_ready", 64'(in_ready_o), 64'd1);
      chk("abort_out_valid", 64'(out_valid_o), 64'd0);
      chk("abort_start", 64'(start_o), 64'd0);
      chk("abort_x", x_o, 64'd0);
      chk("abort_minv", minv_o, 64'd0);
      run(64'd7, 64'd6, 64'd42, 1'b0);

      // Back-to-back with in_valid held high.
      present(64'd3, 64'd5, 64'd17, 64'd5, 64'd15, 64'd15, 1'b0);
      present(64'd7, 64'd6, 64'd23, 64'd5, 64'd2, 64'd42, 1'b0);
      in_valid_i = 1'b0;
      chk("b2b_accept_cycle", 64'(last_acc), 64'(hs_cyc + 1));
      wait_done();

      repeat (3) @(posedge clk);
      #1;
      chk("handshake_count", 64'(n_hs), 64'd9);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mont_mul_feeder.md
MONT_MUL_FEEDER -- requirements
Module: mont_mul_feeder

Interface
REQ-001 Parameter DATA_LENGTH, default 64, operand/modulus word width W (from multiplier_pkg).
REQ-002 clk_i  input  1  single clock, rising-edge active.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 in_valid_i  input  1  upstream operand set valid.
REQ-005 in_ready_o  output  1  block can accept an operand set.
REQ-006 a_i, b_i  input  W each  multiplicands, already in Montgomery form.
REQ-007 m_i, m_bl_i, minv_i  input  W each  modulus, modulus bitlength, modular inverse; passed through.
REQ-008 out_valid_o  output  1  product and side-band valid.
REQ-009 out_ready_i  input  1  downstream reduction stage can take the result.
REQ-010 x_o  output  W  low W bits of a*b, feeds the reduction stage x input.
REQ-011 m_o, m_bl_o, minv_o  output  W each  registered copies of m_i, m_bl_i, minv_i.
REQ-012 start_o  output  1  one-cycle pulse that starts the reduction stage.
REQ-013 ovf_o  output  1  a*b does not fit in W bits.

Function
REQ-014 FSM states: IDLE, MUL, HOLD; reset state IDLE.
REQ-015 in_ready_o SHALL be 1 exactly when the state is IDLE.
REQ-016 IDLE: on in_valid_i=1, latch a, b, m, m_bl, minv; clear 2W-bit accumulator and counter cnt; go to MUL.
REQ-017 MUL: each cycle, if b_reg[cnt]=1 then acc <= acc + (a_reg << cnt), with a_reg zero-extended to 2W bits; cnt increments.
REQ-018 MUL: the cycle that processes cnt=W-1 SHALL transition to HOLD. MUL lasts exactly W cycles.
REQ-019 Latency: out_valid_o SHALL rise W+1 cycles after the accepting clock edge (W=64 gives 65).
REQ-020 HOLD: out_valid_o=1; x_o=acc[W-1:0]; ovf_o=|acc[2W-1:W]; m_o, m_bl_o, minv_o show the latched values.
REQ-021 All outputs SHALL remain stable in HOLD until out_ready_i=1.
REQ-022 start_o = out_valid_o AND out_ready_i; it SHALL pulse for exactly one cycle per result.
REQ-023 HOLD with out_ready_i=1: go to IDLE next cycle. The next operand set is accepted no earlier than the following cycle, so there is no same-cycle pass-through.
REQ-024 in_valid_i during MUL or HOLD SHALL be ignored, with no latch and no effect.
REQ-025 out_ready_i in IDLE or MUL SHALL have no effect.
REQ-026 Outside HOLD: out_valid_o=0, start_o=0, ovf_o=0. x_o, m_o, m_bl_o and minv_o hold their last values.
REQ-027 Arithmetic is unsigned. The accumulator SHALL be 2W bits wide and SHALL NOT wrap for any W-bit inputs.
REQ-028 On overflow, x_o is still the truncated low word and ovf_o=1. The downstream stage decides the action.
REQ-029 a_i=0 or b_i=0 SHALL still take the full W cycles, with result 0 and ovf_o=0.

Reset
REQ-030 rst_i=1 at a clock edge SHALL force IDLE, acc=0, cnt=0 and all output registers to 0. Resulting outputs: in_ready_o=1, out_valid_o=0, start_o=0, ovf_o=0, x_o=0, m_o=0, m_bl_o=0, minv_o=0.
REQ-031 rst_i SHALL take priority over in_valid_i and out_ready_i in the same cycle.
REQ-032 rst_i during MUL or HOLD SHALL abort the operation with no start_o pulse; the operation is not resumed.

Verification (W=64)
REQ-033 Basic: a=3, b=5, m=17, m_bl=5, minv=15, out_ready=1 -> x_o=15, ovf_o=0, m_o=17; out_valid_o at cycle 65; one start_o pulse.
REQ-034 Overflow: a=2^63, b=2 -> x_o=0, ovf_o=1. Max: a=b=2^64-1 -> x_o=1, ovf_o=1.
REQ-035 Backpressure: out_ready=0 for 10 cycles in HOLD, with in_valid pulsed meanwhile -> outputs stable, in_ready_o=0, no new operands latched, start_o only when out_ready rises.
REQ-036 Reset mid-operation: rst_i at MUL cycle 30 -> next cycle in_ready_o=1, out_valid_o=0, no start_o. A new a=7, b=6 then gives x_o=42.
REQ-037 Back-to-back: in_valid held at 1 with two operand sets (3x5, 7x6) -> results 15 then 42, each with one start_o pulse, second accepted one cycle after first handshake.
REQ-038 Zero: a=0, b=0xFFFF_FFFF_FFFF_FFFF -> x_o=0, ovf_o=0, latency still 65.
